lane_ld_wb_buffer: RTL and testbench

//  Per-lane write-back stage directly downstream of the VLSU load path (txs_* lane interface).

---
 rtl/vlsu_pkg.sv | 26 ++
 rtl/QueueFlow.sv | 48 ++++
 rtl/lane_ld_wb_buffer.sv | 172 +++++++++++++++++
 tb/tb_lane_ld_wb_buffer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// vlsu_pkg: shared lane write-back types (ids, VRF address, beat bundle, FSM states).
// LANE_DLEN is the lane datapath width used by the beat bundle.
package vlsu_pkg;

  localparam int LANE_DLEN = 64;
  localparam int LANE_NBE  = LANE_DLEN / 4;

  typedef logic [2:0] vid_t;
  typedef logic [4:0] vaddr_set_t;
  typedef logic [2:0] vaddr_off_t;

  typedef struct packed {
    vid_t                  reqId;
    vaddr_set_t            set;
    vaddr_off_t            off;
    logic [LANE_DLEN-1:0]  data;
    logic [LANE_NBE-1:0]   nbe;
  } lane_wb_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } lane_wb_state_e;

endpackage

// File: rtl/QueueFlow.sv
// QueueFlow: registered-occupancy FIFO, push ignored when full, pop ignored when empty.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i, data_o (head), usage_o (entry count).
module QueueFlow #(
  parameter type T     = logic,
  parameter int  Depth = 4,
  localparam int CW    = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [CW-1:0] usage_o
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  T               mem [Depth];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  usage;
  logic           do_push;
  logic           do_pop;

  assign do_push = push_i && (usage != CW'(Depth));
  assign do_pop  = pop_i && (usage != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      usage <= usage + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  assign data_o  = mem[rd_ptr];
  assign usage_o = usage;

endmodule

// File: rtl/lane_ld_wb_buffer.sv
// lane_ld_wb_buffer: buffers VLSU load beats, drains them to the lane VRF port, pulses per-id done.
// Ports: ld_* beat in, exp_* beat budget in, vrf_* write out, done_* pulse, err_o; LANE_WB_BYPASS_EN adds 0-cycle path.
module lane_ld_wb_buffer
  import vlsu_pkg::*;
#(
  parameter int  DLEN     = LANE_DLEN,
  parameter int  Depth    = 4,
  parameter int  ExpDepth = 2,
  parameter int  MaxBeats = 256,
  localparam int BW       = $clog2(MaxBeats + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  vid_t              ld_reqId_i,
  input  vaddr_set_t        ld_vaddr_set_i,
  input  vaddr_off_t        ld_vaddr_off_i,
  input  logic [DLEN-1:0]   ld_data_i,
  input  logic [DLEN/4-1:0] ld_nbe_i,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  vid_t              exp_reqId_i,
  input  logic [BW-1:0]     exp_beats_i,
  output logic              vrf_req_o,
  input  logic              vrf_gnt_i,
  output vaddr_set_t        vrf_set_o,
  output vaddr_off_t        vrf_off_o,
  output logic [DLEN-1:0]   vrf_wdata_o,
  output logic [DLEN/4-1:0] vrf_wnbe_o,
  output logic              done_valid_o,
  output vid_t              done_reqId_o,
  output logic              err_o
);

  typedef struct packed {
    vid_t          id;
    logic [BW-1:0] beats;
  } budget_t;

  localparam int BCW = $clog2(Depth + 1);
  localparam int ECW = $clog2(ExpDepth + 1);

  lane_wb_beat_t  in_beat;
  lane_wb_beat_t  head;
  lane_wb_beat_t  out_beat;
  budget_t        in_bud;
  budget_t        bud;
  logic [BCW-1:0] b_use;
  logic [ECW-1:0] e_use;
  logic           b_empty;
  logic           b_push;
  logic           b_pop;
  logic           e_empty;
  logic           e_push;
  logic           e_pop;
  logic           drain;
  logic           byp;
  logic           byp_commit;
  logic           commit;
  vid_t           commit_id;
  lane_wb_state_e state;
  lane_wb_state_e state_n;
  logic [BW-1:0]  cnt;
  logic [BW-1:0]  cnt_n;

  assign in_beat = '{
    reqId: ld_reqId_i,
    set:   ld_vaddr_set_i,
    off:   ld_vaddr_off_i,
    data:  ld_data_i,
    nbe:   ld_nbe_i
  };
  assign in_bud = '{id: exp_reqId_i, beats: exp_beats_i};

  QueueFlow #(
    .T     (lane_wb_beat_t),
    .Depth (Depth)
  ) u_beat_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (b_push),
    .data_i  (in_beat),
    .pop_i   (b_pop),
    .data_o  (head),
    .usage_o (b_use)
  );

  QueueFlow #(
    .T     (budget_t),
    .Depth (ExpDepth)
  ) u_bud_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (e_push),
    .data_i  (in_bud),
    .pop_i   (e_pop),
    .data_o  (bud),
    .usage_o (e_use)
  );

  // Ready flags depend only on stored occupancy, never on a same-cycle pop.
  assign ld_ready_o  = (b_use != BCW'(Depth));
  assign exp_ready_o = (e_use != ECW'(ExpDepth));
  assign b_empty     = (b_use == '0);
  assign e_empty     = (e_use == '0);
  assign e_push      = exp_valid_i && exp_ready_o;

  // The budget head is the active instruction; it only pops in DONE.
  assign drain = (state == ACTIVE) && (cnt != bud.beats);

`ifdef LANE_WB_BYPASS_EN
  assign byp      = drain && b_empty && ld_valid_i && (ld_nbe_i != '0);
  assign out_beat = byp ? in_beat : head;
`else
  assign byp      = 1'b0;
  assign out_beat = head;
`endif

  assign byp_commit = byp && vrf_gnt_i;
  assign b_pop      = drain && !b_empty && ((head.nbe == '0) || vrf_gnt_i);
  assign commit     = b_pop || byp_commit;
  assign commit_id  = out_beat.reqId;
  assign b_push     = ld_valid_i && ld_ready_o && !byp_commit;

  assign vrf_req_o   = (drain && !b_empty && (head.nbe != '0)) || byp;
  assign vrf_set_o   = out_beat.set;
  assign vrf_off_o   = out_beat.off;
  assign vrf_wdata_o = out_beat.data;
  assign vrf_wnbe_o  = out_beat.nbe;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    e_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!e_empty) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end
      end
      ACTIVE: begin
        if (commit) cnt_n = cnt + BW'(1);
        if (cnt + BW'(commit) == bud.beats) state_n = DONE;
      end
      DONE: begin
        e_pop   = 1'b1;
        cnt_n   = '0;
        state_n = (e_use > ECW'(1)) ? ACTIVE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      done_valid_o <= 1'b0;
      done_reqId_o <= '0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      done_valid_o <= (state_n == DONE);
      if (state_n == DONE) done_reqId_o <= bud.id;
      if (commit && (commit_id != bud.id)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_ld_wb_buffer.sv
// tb_lane_ld_wb_buffer: scoreboard bench; expected writes/done ids queued at issue, popped by a monitor.
// Model: writes are the non-zero-nbe beats in issue order; done ids follow budget order.
`timescale 1ns/1ps
module tb_lane_ld_wb_buffer;
  import vlsu_pkg::*;

  localparam int DL = LANE_DLEN;
  localparam int NB = DL / 4;
  localparam int BW = $clog2(256 + 1);
`ifdef LANE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready_o;
  vid_t          ld_reqId = '0;
  vaddr_set_t    ld_set = '0;
  vaddr_off_t    ld_off = '0;
  logic [DL-1:0] ld_data = '0;
  logic [NB-1:0] ld_nbe = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ready_o;
  vid_t          exp_reqId = '0;
  logic [BW-1:0] exp_beats = '0;
  logic          vrf_req_o;
  logic          vrf_gnt = 1'b0;
  vaddr_set_t    vrf_set_o;
  vaddr_off_t    vrf_off_o;
  logic [DL-1:0] vrf_wdata_o;
  logic [NB-1:0] vrf_wnbe_o;
  logic          done_valid_o;
  vid_t          done_reqId_o;
  logic          err_o;

  always #5 clk = ~clk;

  lane_ld_wb_buffer dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ld_valid_i     (ld_valid),
    .ld_ready_o     (ld_ready_o),
    .ld_reqId_i     (ld_reqId),
    .ld_vaddr_set_i (ld_set),
    .ld_vaddr_off_i (ld_off),
    .ld_data_i      (ld_data),
    .ld_nbe_i       (ld_nbe),
    .exp_valid_i    (exp_valid),
    .exp_ready_o    (exp_ready_o),
    .exp_reqId_i    (exp_reqId),
    .exp_beats_i    (exp_beats),
    .vrf_req_o      (vrf_req_o),
    .vrf_gnt_i      (vrf_gnt),
    .vrf_set_o      (vrf_set_o),
    .vrf_off_o      (vrf_off_o),
    .vrf_wdata_o    (vrf_wdata_o),
    .vrf_wnbe_o     (vrf_wnbe_o),
    .done_valid_o   (done_valid_o),
    .done_reqId_o   (done_reqId_o),
    .err_o          (err_o)
  );

  typedef struct {
    logic [87:0] f;
    int          tag;
  } wr_t;
  typedef struct {
    vid_t id;
    int   tag;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  checks = 0;
  int  passed = 0;
  int  wr_n = 0;
  int  acc_n = 0;
  int  tag_n = 0;
  bit  mon_en = 1'b0;
  bit  rand_on = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  logic [87:0] fields;
  assign fields = {vrf_set_o, vrf_off_o, vrf_wdata_o, vrf_wnbe_o};

  bit          hold = 1'b0;
  bit          prev_done = 1'b0;
  logic [87:0] prev_f = '0;

  always @(negedge clk) begin
    if (mon_en && rst_ni) begin
      if (hold) chk("vrf_hold", 128'({vrf_req_o, fields}), 128'({1'b1, prev_f}));
      if (vrf_req_o && vrf_gnt) begin
        wr_n++;
        if (wq.size() == 0) chk("vrf_extra", 128'(wq.size()), 128'(1));
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("vrf_write", 128'(fields), 128'(w.f));
        end
      end
      hold   = vrf_req_o && !vrf_gnt;
      prev_f = fields;
      if (done_valid_o) begin
        chk("done_pulse", 128'(prev_done), 128'(0));
        if (dq.size() == 0) chk("done_extra", 128'(dq.size()), 128'(1));
        else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_id", 128'(done_reqId_o), 128'(d.id));
          if (wq.size() != 0) chk("done_order", 128'(wq[0].tag > d.tag), 128'(1));
        end
      end
      prev_done = done_valid_o;
    end else begin
      hold      = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic prog(vid_t id, int n, int tag);
    int t = 0;
    bit acc;
    dq.push_back('{id: id, tag: tag});
    exp_valid = 1'b1;
    exp_reqId = id;
    exp_beats = BW'(n);
    forever begin
      @(negedge clk);
      acc = exp_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      if (++t > 3000) begin
        chk("exp_timeout", 128'(t), 128'(0));
        break;
      end
    end
    exp_valid = 1'b0;
  endtask

  task automatic send(vid_t id, logic [NB-1:0] nbe, int tag);
    int t = 0;
    bit acc;
    vaddr_set_t    s = vaddr_set_t'($urandom);
    vaddr_off_t    o = vaddr_off_t'($urandom);
    logic [DL-1:0] d = {$urandom, $urandom};
    if (nbe != '0) wq.push_back('{f: {s, o, d, nbe}, tag: tag});
    ld_valid = 1'b1;
    ld_reqId = id;
    ld_set   = s;
    ld_off   = o;
    ld_data  = d;
    ld_nbe   = nbe;
    forever begin
      @(negedge clk);
      acc = ld_ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_n++;
        break;
      end
      if (++t > 3000) begin
        chk("ld_timeout", 128'(t), 128'(0));
        break;
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int t = 0;
    while ((wq.size() != 0 || dq.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 128'(wq.size() + dq.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] rnbe();
    return NB'($urandom) | NB'(1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int a0;
    int nb[12];
    vid_t ids[12];
    int base;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_ready", 128'(ld_ready_o), 128'(1));
    chk("rst_exp_ready", 128'(exp_ready_o), 128'(1));
    chk("rst_vrf_req", 128'(vrf_req_o), 128'(0));
    chk("rst_done", 128'(done_valid_o), 128'(0));
    chk("rst_done_id", 128'(done_reqId_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // basic 4-beat instruction
    vrf_gnt = 1'b1;
    w0 = wr_n;
    prog(3'd3, 4, tag_n);
    for (int i = 0; i < 4; i++) send(3'd3, rnbe(), tag_n);
    tag_n++;
    wait_drain("t1_drain");
    chk("t1_writes", 128'(wr_n - w0), 128'(4));
    chk("t1_err", 128'(err_o), 128'(0));

    // backpressure with grant held low
    vrf_gnt = 1'b0;
    w0 = wr_n;
    prog(3'd1, 6, tag_n);
    a0 = acc_n;
    fork
      begin
        int tg = tag_n;
        for (int i = 0; i < 6; i++) send(3'd1, rnbe(), tg);
      end
    join_none
    repeat (10) @(negedge clk);
    chk("t2_accepted", 128'(acc_n - a0), 128'(4));
    chk("t2_ld_ready", 128'(ld_ready_o), 128'(0));
    chk("t2_vrf_req", 128'(vrf_req_o), 128'(1));
    @(posedge clk);
    #1;
    vrf_gnt = 1'b1;
    tag_n++;
    wait_drain("t2_drain");
    chk("t2_writes", 128'(wr_n - w0), 128'(6));

    // zero-nbe beat counts but does not write
    w0 = wr_n;
    prog(3'd2, 3, tag_n);
    send(3'd2, rnbe(), tag_n);
    send(3'd2, '0, tag_n);
    send(3'd2, rnbe(), tag_n);
    tag_n++;
    wait_drain("t3_drain");
    chk("t3_writes", 128'(wr_n - w0), 128'(2));

    // zero-beat budget followed by a 2-beat budget
    w0 = wr_n;
    prog(3'd1, 0, tag_n);
    prog(3'd2, 2, tag_n + 1);
    send(3'd2, rnbe(), tag_n + 1);
    send(3'd2, rnbe(), tag_n + 1);
    tag_n += 2;
    wait_drain("t4_drain");
    chk("t4_writes", 128'(wr_n - w0), 128'(2));

    // id mismatch is sticky
    prog(3'd4, 1, tag_n);
    send(3'd5, rnbe(), tag_n);
    tag_n++;
    wait_drain("t5_drain");
    chk("t5_err", 128'(err_o), 128'(1));
    prog(3'd6, 1, tag_n);
    send(3'd6, rnbe(), tag_n);
    tag_n++;
    wait_drain("t5_drain2");
    chk("t5_err_sticky", 128'(err_o), 128'(1));

    // reset in the middle of a drain
    vrf_gnt = 1'b0;
    prog(3'd7, 2, tag_n);
    send(3'd7, rnbe(), tag_n);
    send(3'd7, rnbe(), tag_n);
    tag_n++;
    @(negedge clk);
    chk("t5_pre_rst_req", 128'(vrf_req_o), 128'(1));
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mrst_ld_ready", 128'(ld_ready_o), 128'(1));
    chk("mrst_exp_ready", 128'(exp_ready_o), 128'(1));
    chk("mrst_vrf_req", 128'(vrf_req_o), 128'(0));
    chk("mrst_done", 128'(done_valid_o), 128'(0));
    chk("mrst_done_id", 128'(done_reqId_o), 128'(0));
    chk("mrst_err", 128'(err_o), 128'(0));
    wq.delete();
    dq.delete();
    @(posedge clk);
    #1;
    rst_ni  = 1'b1;
    mon_en  = 1'b1;
    vrf_gnt = 1'b1;

    // write latency from an empty FIFO in ACTIVE
    prog(3'd6, 1, tag_n);
    repeat (3) @(posedge clk);
    #1;
    begin
      vaddr_set_t    s = vaddr_set_t'($urandom);
      vaddr_off_t    o = vaddr_off_t'($urandom);
      logic [DL-1:0] d = {$urandom, $urandom};
      logic [NB-1:0] n = rnbe();
      wq.push_back('{f: {s, o, d, n}, tag: tag_n});
      ld_valid = 1'b1;
      ld_reqId = 3'd6;
      ld_set   = s;
      ld_off   = o;
      ld_data  = d;
      ld_nbe   = n;
    end
    @(negedge clk);
    chk("t6_lat0", 128'(vrf_req_o), 128'(BYP));
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("t6_lat1", 128'(vrf_req_o), 128'(!BYP));
    tag_n++;
    wait_drain("t6_drain");

    // randomized traffic with random grant
    for (int i = 0; i < 12; i++) begin
      nb[i]  = $urandom_range(0, 5);
      ids[i] = vid_t'($urandom);
    end
    base  = tag_n;
    tag_n += 12;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          vrf_gnt = ($urandom_range(0, 2) != 0);
        end
        vrf_gnt = 1'b1;
      end
    join_none
    fork
      begin
        for (int i = 0; i < 12; i++) prog(ids[i], nb[i], base + i);
      end
      begin
        for (int i = 0; i < 12; i++)
          for (int j = 0; j < nb[i]; j++)
            send(ids[i], ($urandom_range(0, 3) == 0) ? '0 : rnbe(), base + i);
      end
    join
    wait_drain("rand_drain");
    rand_on = 1'b0;
    chk("rand_err", 128'(err_o), 128'(0));

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
